pc_redirect_ctrl: RTL and testbench

Sequencer for the instruction fetch unit's PC. Each cycle it decides whether the PC holds, increments, or loads a new target. It arbitrates redirect requests from exception, EX-stage branch and ID-stage jump sources, and remembers a redirect that arrives while fetch is stalled. It drives the fetch unit's `stall`/`rw`/`write` inputs and the pipeline flush lines.

---
 rtl/pc_redirect_if.sv | 35 +++
 rtl/pc_redirect_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_if.sv
// Redirect request / fetch control bundle between the pipeline and pc_redirect_ctrl.
// master = pipeline side (raises requests, consumes fetch controls); slave = controller.
interface pc_redirect_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  hazard_stall;
    logic                  imem_ready;
    logic                  exc_req;
    logic [DATA_WIDTH-1:0] exc_target;
    logic                  br_req;
    logic [DATA_WIDTH-1:0] br_target;
    logic                  jmp_req;
    logic [DATA_WIDTH-1:0] jmp_target;
    logic                  fetch_stall;
    logic                  fetch_rw;
    logic [DATA_WIDTH-1:0] fetch_write;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  pending;
    logic                  redirect_fault;

    modport master (
        output hazard_stall, imem_ready,
        output exc_req, exc_target, br_req, br_target, jmp_req, jmp_target,
        input  fetch_stall, fetch_rw, fetch_write,
        input  flush_if_id, flush_id_ex, pending, redirect_fault
    );

    modport slave (
        input  hazard_stall, imem_ready,
        input  exc_req, exc_target, br_req, br_target, jmp_req, jmp_target,
        output fetch_stall, fetch_rw, fetch_write,
        output flush_if_id, flush_id_ex, pending, redirect_fault
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC sequencer for the fetch unit: arbitrates exc > br > jmp redirects, holds one across stalls.
// Optional feature macro PC_ALIGN_CHECK_EN: misaligned targets are replaced by EXC_VECTOR.
module pc_redirect_ctrl #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DRAIN_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic         clk,
    input  logic         rst,
    pc_redirect_if.slave bus
);
    // fetch unit rw encoding: write loads fetch_write, read increments the PC
    localparam logic       MEM_READ   = 1'b0;
    localparam logic       MEM_WRITE  = 1'b1;
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;
    typedef enum logic [1:0] {K_JMP, K_BR, K_EXC} kind_t;

    state_t                state_reg, state_next;
    kind_t                 pend_kind_reg, pend_kind_next;
    logic [DATA_WIDTH-1:0] pend_target_reg, pend_target_next;
    logic [3:0]            drain_cnt_reg, drain_cnt_next;

    logic                  stall_in;
    logic                  req_any;
    kind_t                 req_kind;
    logic [DATA_WIDTH-1:0] req_target;
    kind_t                 hold_kind;
    logic [DATA_WIDTH-1:0] hold_target;
    logic                  apply;
    kind_t                 apply_kind;
    logic [DATA_WIDTH-1:0] apply_target;
    logic                  align_bad;
    logic [DATA_WIDTH-1:0] applied_target;

`ifdef PC_ALIGN_CHECK_EN
    logic fault_reg;
    assign align_bad = apply && (apply_target[1:0] != 2'b00);
`else
    assign align_bad = 1'b0;
`endif
    assign applied_target = align_bad ? EXC_VECTOR : apply_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            pend_kind_reg   <= K_JMP;
            pend_target_reg <= '0;
            drain_cnt_reg   <= 4'd0;
        end else begin
            state_reg       <= state_next;
            pend_kind_reg   <= pend_kind_next;
            pend_target_reg <= pend_target_next;
            drain_cnt_reg   <= drain_cnt_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) fault_reg <= 1'b0;
        else     fault_reg <= align_bad;
    end
`endif

    always_comb begin
        stall_in         = bus.hazard_stall | ~bus.imem_ready;
        req_any          = bus.exc_req | bus.br_req | bus.jmp_req;
        req_kind         = K_JMP;
        req_target       = bus.jmp_target;
        if (bus.exc_req) begin
            req_kind   = K_EXC;
            req_target = bus.exc_target;
        end else if (bus.br_req) begin
            req_kind   = K_BR;
            req_target = bus.br_target;
        end

        state_next       = state_reg;
        pend_kind_next   = pend_kind_reg;
        pend_target_next = pend_target_reg;
        drain_cnt_next   = drain_cnt_reg;
        hold_kind        = pend_kind_reg;
        hold_target      = pend_target_reg;
        apply            = 1'b0;
        apply_kind       = K_JMP;
        apply_target     = '0;
        bus.fetch_stall  = stall_in;
        bus.flush_if_id  = 1'b0;
        bus.flush_id_ex  = 1'b0;

        case (state_reg)
            RUN: begin
                if (req_any) begin
                    bus.flush_if_id = 1'b1;
                    bus.flush_id_ex = (req_kind != K_JMP);
                    if (!stall_in) begin
                        apply        = 1'b1;
                        apply_kind   = req_kind;
                        apply_target = req_target;
                    end else begin
                        pend_kind_next   = req_kind;
                        pend_target_next = req_target;
                        state_next       = HOLD;
                        bus.fetch_stall  = 1'b1;
                    end
                end
            end
            HOLD: begin
                // overwrite first so a same-cycle release uses the newer redirect
                if (bus.exc_req) begin
                    hold_kind       = K_EXC;
                    hold_target     = bus.exc_target;
                    bus.flush_if_id = 1'b1;
                    bus.flush_id_ex = 1'b1;
                end else if (bus.br_req && pend_kind_reg == K_JMP) begin
                    hold_kind       = K_BR;
                    hold_target     = bus.br_target;
                    bus.flush_if_id = 1'b1;
                    bus.flush_id_ex = 1'b1;
                end
                pend_kind_next   = hold_kind;
                pend_target_next = hold_target;
                if (!stall_in) begin
                    apply            = 1'b1;
                    apply_kind       = hold_kind;
                    apply_target     = hold_target;
                    pend_kind_next   = K_JMP;
                    pend_target_next = '0;
                end
            end
            DRAIN: begin
                bus.fetch_stall = 1'b1;
                if (bus.exc_req) begin
                    bus.flush_if_id = 1'b1;
                    bus.flush_id_ex = 1'b1;
                    apply           = 1'b1;
                    apply_kind      = K_EXC;
                    apply_target    = bus.exc_target;
                end else if (drain_cnt_reg <= 4'd1) begin
                    drain_cnt_next = 4'd0;
                    state_next     = RUN;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 4'd1;
                end
            end
            default: state_next = RUN;
        endcase

        bus.fetch_rw    = MEM_READ;
        bus.fetch_write = '0;
        if (apply) begin
            bus.fetch_stall = 1'b0;
            bus.fetch_rw    = MEM_WRITE;
            bus.fetch_write = applied_target;
            if (apply_kind == K_EXC || align_bad) begin
                state_next     = DRAIN;
                drain_cnt_next = DRAIN_LOAD;
            end else begin
                state_next     = RUN;
            end
        end

        bus.pending = (state_reg == HOLD);
        if (rst) begin
            bus.fetch_stall = 1'b1;
            bus.fetch_rw    = MEM_READ;
            bus.fetch_write = '0;
            bus.flush_if_id = 1'b1;
            bus.flush_id_ex = 1'b1;
            bus.pending     = 1'b0;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign bus.redirect_fault = fault_reg & ~rst;
`else
    assign bus.redirect_fault = 1'b0;
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios then random traffic, checked against a
// redirect-rank/drain-count model and a fetch-unit PC driven by the controller outputs.
module tb_pc_redirect_ctrl;
    localparam int          DRAIN     = 2;
    localparam logic [31:0] EXC_VEC   = 32'h0000_0180;
    localparam logic        MEM_READ  = 1'b0;
    localparam logic        MEM_WRITE = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    int          n_checks = 0;
    int          n_pass   = 0;

    // model: pending redirect as (rank 1=jmp 2=br 3=exc, target), drain cycles left
    bit          m_pend  = 0;
    int          m_rank  = 0;
    logic [31:0] m_ptgt  = '0;
    int          m_drain = 0;
    bit          m_fault = 0;

    pc_redirect_if #(.DATA_WIDTH(32)) bus ();

    pc_redirect_ctrl #(
        .DATA_WIDTH  (32),
        .DRAIN_CYCLES(DRAIN),
        .EXC_VECTOR  (EXC_VEC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // fetch unit: holds on stall, loads on write, otherwise advances by 4
    always @(posedge clk) begin
        if (rst)                          pc <= '0;
        else if (!bus.fetch_stall) begin
            if (bus.fetch_rw == MEM_WRITE) pc <= bus.fetch_write;
            else                           pc <= pc + 32'd4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input string tag, input bit r, input bit hz, input bit rdy,
                        input bit ex, input logic [31:0] et, input bit b, input logic [31:0] bt,
                        input bit j, input logic [31:0] jt);
        bit          stall_in, apply, bad;
        int          req_rank, app_rank, eff_rank;
        logic [31:0] req_tgt, app_tgt, eff_tgt, wr;
        bit          e_stall, e_rw, e_fii, e_fie, e_pend, e_fault;
        @(negedge clk);
        rst = r;
        bus.hazard_stall = hz; bus.imem_ready = rdy;
        bus.exc_req = ex; bus.exc_target = et;
        bus.br_req  = b;  bus.br_target  = bt;
        bus.jmp_req = j;  bus.jmp_target = jt;
        #1;
        stall_in = hz || !rdy;
        req_rank = ex ? 3 : b ? 2 : j ? 1 : 0;
        req_tgt  = ex ? et : b ? bt : jt;
        e_stall = stall_in; e_rw = MEM_READ; wr = '0; e_fii = 0; e_fie = 0;
        e_pend = m_pend; e_fault = m_fault;
        apply = 0; app_rank = 0; app_tgt = '0; eff_rank = m_rank; eff_tgt = m_ptgt;
        if (m_drain > 0) begin
            e_stall = 1;
            if (ex) begin apply = 1; app_rank = 3; app_tgt = et; e_fii = 1; e_fie = 1; end
        end else if (m_pend) begin
            if (ex) begin eff_rank = 3; eff_tgt = et; e_fii = 1; e_fie = 1; end
            else if (b && m_rank == 1) begin eff_rank = 2; eff_tgt = bt; e_fii = 1; e_fie = 1; end
            if (!stall_in) begin apply = 1; app_rank = eff_rank; app_tgt = eff_tgt; end
        end else if (req_rank > 0) begin
            e_fii = 1; e_fie = (req_rank >= 2);
            if (!stall_in) begin apply = 1; app_rank = req_rank; app_tgt = req_tgt; end
            else e_stall = 1;
        end
        bad = 0;
`ifdef PC_ALIGN_CHECK_EN
        bad = apply && (app_tgt[1:0] != 2'b00);
`endif
        if (apply) begin e_stall = 0; e_rw = MEM_WRITE; wr = bad ? EXC_VEC : app_tgt; end
        if (r) begin
            e_stall = 1; e_rw = MEM_READ; wr = '0; e_fii = 1; e_fie = 1; e_pend = 0; e_fault = 0;
        end
        chk({tag, ".fetch_stall"},    32'(bus.fetch_stall),    32'(e_stall));
        chk({tag, ".fetch_rw"},       32'(bus.fetch_rw),       32'(e_rw));
        chk({tag, ".fetch_write"},    bus.fetch_write,         wr);
        chk({tag, ".flush_if_id"},    32'(bus.flush_if_id),    32'(e_fii));
        chk({tag, ".flush_id_ex"},    32'(bus.flush_id_ex),    32'(e_fie));
        chk({tag, ".pending"},        32'(bus.pending),        32'(e_pend));
        chk({tag, ".redirect_fault"}, 32'(bus.redirect_fault), 32'(e_fault));
        @(posedge clk);
        #1;
        if (r) begin
            m_pend = 0; m_rank = 0; m_drain = 0; m_fault = 0;
        end else begin
            m_fault = bad;
            if (apply) begin
                m_pend  = 0;
                m_drain = (app_rank == 3 || bad) ? DRAIN : 0;
            end else if (m_drain > 0) begin
                m_drain--;
            end else if (m_pend) begin
                m_rank = eff_rank; m_ptgt = eff_tgt;
            end else if (req_rank > 0) begin
                m_pend = 1; m_rank = req_rank; m_ptgt = req_tgt;
            end
        end
        $display("step %-10s rst=%0b hz=%0b rdy=%0b exc=%0b br=%0b jmp=%0b -> stall=%0b rw=%0b wr=%08h pc=%08h",
                 tag, r, hz, rdy, ex, b, j, bus.fetch_stall, e_rw, wr, pc);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 1, 0, '0, 0, '0, 0, '0);
    endtask

    initial begin
        logic [31:0] t[3];
        rst = 1'b1;
        bus.hazard_stall = 0; bus.imem_ready = 1;
        bus.exc_req = 0; bus.br_req = 0; bus.jmp_req = 0;
        bus.exc_target = '0; bus.br_target = '0; bus.jmp_target = '0;

        step("reset", 1, 0, 1, 0, '0, 0, '0, 0, '0);
        step("reset", 1, 0, 1, 0, '0, 0, '0, 0, '0);
        chk("pc_after_reset", pc, 32'h0);
        idle("run");       chk("pc_run0", pc, 32'h4);
        idle("run");       chk("pc_run1", pc, 32'h8);

        step("priority", 0, 0, 1, 1, 32'h180, 1, 32'h40, 1, 32'h80);
        chk("pc_priority", pc, 32'h180);
        idle("drain");     chk("pc_drain0", pc, 32'h180);
        idle("drain");     chk("pc_drain1", pc, 32'h180);
        idle("run");       chk("pc_post_drain", pc, 32'h184);

        repeat (3) step("br_stall", 0, 1, 1, 0, '0, 1, 32'h100, 0, '0);
        chk("pc_frozen", pc, 32'h184);
        idle("release");   chk("pc_release", pc, 32'h100);
        idle("run");       chk("pc_after_rel", pc, 32'h104);

        step("jmp_hold", 0, 0, 0, 0, '0, 0, '0, 1, 32'h200);
        step("br_over",  0, 0, 0, 0, '0, 1, 32'h300, 0, '0);
        step("jmp_ign",  0, 0, 0, 0, '0, 0, '0, 1, 32'h400);
        idle("release");   chk("pc_overwrite", pc, 32'h300);

        step("exc_run",  0, 0, 1, 1, 32'h600, 0, '0, 0, '0);
        step("br_drain", 0, 0, 1, 0, '0, 1, 32'h40, 0, '0);
        chk("pc_br_drain", pc, 32'h600);
        step("exc_drain", 0, 0, 1, 1, 32'h500, 0, '0, 0, '0);
        chk("pc_exc_drain", pc, 32'h500);
        idle("drain");
        idle("drain");     chk("pc_reload", pc, 32'h500);
        idle("run");       chk("pc_after_reload", pc, 32'h504);

        step("jmp_mis", 0, 0, 1, 0, '0, 0, '0, 1, 32'h102);
`ifdef PC_ALIGN_CHECK_EN
        chk("pc_misaligned", pc, EXC_VEC);
`else
        chk("pc_misaligned", pc, 32'h102);
`endif
        repeat (3) idle("after_mis");

        step("br_hold", 0, 1, 1, 0, '0, 1, 32'h700, 0, '0);
        step("rst_hold", 1, 1, 1, 0, '0, 0, '0, 0, '0);
        idle("run");       chk("pc_rst_hold", pc, 32'h4);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++)
                t[k] = ($urandom & 32'hFFFF_FFFC) |
                       (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
            step("random", $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0, t[0],
                 $urandom_range(0, 5) == 0, t[1], $urandom_range(0, 4) == 0, t[2]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
